alien_formation_ctrl: RTL and testbench

Parametrised alien-formation engine, the next generation of the fixed 256x128 alien matrix. It holds a ROWS x COLS alive map and marches the formation across the screen once per frame period. It speeds up as aliens die, resolves player-shot hits to an exact cell, and renders per-pixel drawing requests with cell offsets for the bitmap ROM. It sits between the VGA pixel counter and the object mux, alongside the player and shot blocks.

---
 rtl/alien_formation_pkg.sv | 29 ++
 rtl/alien_span_finder.sv | 43 ++++
 rtl/alien_formation_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_alien_formation_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_formation_pkg.sv
// Shared types and helpers for the alien formation engine.
// Holds the movement state encoding, march direction, speed curve and wave hold length.
package alien_formation_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_STEP,
      ST_DESCEND,
      ST_DEFEATED
   } state_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

   localparam int WAVE_HOLD_FRAMES = 60;

   // Every dead alien shortens the move period by one frame, floored at min_p.
   function automatic logic [7:0] calc_period(input int base, input int min_p,
                                              input int total, input logic [7:0] alive);
      int p;
      p = base - (total - int'(alive));
      if (p < min_p) p = min_p;
      return 8'(p);
   endfunction

endpackage

// File: rtl/alien_span_finder.sv
// Combinational extent of the live formation: leftmost/rightmost live column and lowest live row.
// Drives both the march edge check and the bottom-edge report.
module alien_span_finder #(
   parameter int ROWS = 4,
   parameter int COLS = 8
) (
   input  logic [ROWS*COLS-1:0] alive_i,
   output logic [3:0]           min_col_o,
   output logic [3:0]           max_col_o,
   output logic [2:0]           max_row_o,
   output logic                 any_o
);

   logic [COLS-1:0] col_live;
   logic [ROWS-1:0] row_live;

   always_comb begin
      col_live  = '0;
      row_live  = '0;
      min_col_o = '0;
      max_col_o = '0;
      max_row_o = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (alive_i[r*COLS+c]) begin
               col_live[c] = 1'b1;
               row_live[r] = 1'b1;
            end
         end
      end
      for (int c = COLS - 1; c >= 0; c--) begin
         if (col_live[c]) min_col_o = 4'(c);
      end
      for (int c = 0; c < COLS; c++) begin
         if (col_live[c]) max_col_o = 4'(c);
      end
      for (int r = 0; r < ROWS; r++) begin
         if (row_live[r]) max_row_o = 3'(r);
      end
      any_o = |alive_i;
   end

endmodule

// File: rtl/alien_formation_ctrl.sv
// Alien formation: alive map, frame-paced march with descend on edge, hit decode and kill.
// Define ALIEN_FORMATION_WAVE_EN to refill the map after a 60-frame defeat hold (else defeat is terminal).
module alien_formation_ctrl
   import alien_formation_pkg::*;
#(
   parameter int ROWS        = 4,
   parameter int COLS        = 8,
   parameter int CELL_W      = 32,
   parameter int CELL_H      = 32,
   parameter int SCREEN_W    = 640,
   parameter int START_X     = 64,
   parameter int START_Y     = 32,
   parameter int STEP_X      = 4,
   parameter int STEP_Y      = 16,
   parameter int BASE_PERIOD = 32,
   parameter int MIN_PERIOD  = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        playGame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        fireCollision,
   output logic        drawingRequest,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic [1:0]  alienType,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic [7:0]  aliveCount,
   output logic [10:0] bottomY,
   output logic        killPulse,
   output logic        matrixDefeated
);

   localparam int TOTAL  = ROWS * COLS;
   localparam int CW_SH  = $clog2(CELL_W);
   localparam int CH_SH  = $clog2(CELL_H);
   localparam int FORM_W = COLS * CELL_W;
   localparam int FORM_H = ROWS * CELL_H;
   localparam logic [TOTAL-1:0]  LSB = TOTAL'(1);
   localparam logic signed [12:0] SX  = 13'(STEP_X);
   localparam logic signed [12:0] SCR = 13'(SCREEN_W);

   state_t            state_q, state_d;
   dir_t              dir_q, dir_d;
   logic [10:0]       x_q, x_d, y_q, y_d;
   logic [7:0]        frm_q, frm_d;
   logic [TOTAL-1:0]  alive_q, alive_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              kill_q, kill_d;
   logic              draw_q, draw_d;
   logic [10:0]       offx_q, offx_d, offy_q, offy_d;
   logic [1:0]        type_q, type_d;
   logic [6:0]        hidx_q, hidx_d;
`ifdef ALIEN_FORMATION_WAVE_EN
   logic [2:0]        wave_q, wave_d, wave_nxt;
`endif

   logic [3:0]        min_col, max_col;
   logic [2:0]        max_row;
   logic              span_any;

   alien_span_finder #(.ROWS(ROWS), .COLS(COLS)) u_span (
      .alive_i   (alive_q),
      .min_col_o (min_col),
      .max_col_o (max_col),
      .max_row_o (max_row),
      .any_o     (span_any)
   );

   logic [10:0]       rel_x, rel_y;
   logic              in_form, hit, kill;
   logic [3:0]        cell_col;
   logic [2:0]        cell_row;
   logic [6:0]        cell_idx;
   logic [TOTAL-1:0]  alive_sh, kill_sh;
   logic signed [12:0] nx, l_off, r_off, l_pos, r_pos;
   logic              at_edge;
   logic [7:0]        period;
   logic [8:0]        frm_inc;

   // Negative offsets wrap to large unsigned values and fall outside the formation box.
   always_comb begin
      rel_x    = pixelX - x_q;
      rel_y    = pixelY - y_q;
      in_form  = ({1'b0, rel_x} < 12'(FORM_W)) && ({1'b0, rel_y} < 12'(FORM_H));
      cell_col = 4'(rel_x >> CW_SH);
      cell_row = 3'(rel_y >> CH_SH);
      cell_idx = 7'(int'(cell_row) * COLS + int'(cell_col));
      alive_sh = alive_q >> cell_idx;
      hit      = in_form && alive_sh[0];
      kill_sh  = alive_q >> hidx_q;
      kill     = fireCollision && draw_q && kill_sh[0];
   end

   always_comb begin
      nx      = (dir_q == DIR_RIGHT) ? $signed({2'b00, x_q}) + SX : $signed({2'b00, x_q}) - SX;
      l_off   = 13'(min_col) << CW_SH;
      r_off   = (13'(max_col) + 13'd1) << CW_SH;
      l_pos   = nx + l_off;
      r_pos   = nx + r_off;
      at_edge = (l_pos < 13'sd0) || (r_pos > SCR);
      period  = calc_period(BASE_PERIOD, MIN_PERIOD, TOTAL, cnt_q);
      frm_inc = {1'b0, frm_q} + 9'd1;
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      x_d     = x_q;
      y_d     = y_q;
      frm_d   = frm_q;
      alive_d = alive_q;
      cnt_d   = cnt_q;
      kill_d  = kill;
      draw_d  = hit;
      offx_d  = rel_x & 11'(CELL_W - 1);
      offy_d  = rel_y & 11'(CELL_H - 1);
      type_d  = 2'(cell_row >> 1);
      hidx_d  = cell_idx;
`ifdef ALIEN_FORMATION_WAVE_EN
      wave_d   = wave_q;
      wave_nxt = (wave_q == 3'd7) ? 3'd7 : wave_q + 3'd1;
`endif

      if (kill) begin
         alive_d = alive_q & ~(LSB << hidx_q);
         cnt_d   = cnt_q - 8'd1;
      end

      // The edge check reads alive_q, so a same-cycle kill does not affect this move.
      if (cnt_q == 8'd0 && state_q != ST_DEFEATED) begin
         state_d = ST_DEFEATED;
         frm_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               frm_d = '0;
               if (playGame) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (!playGame) begin
                  state_d = ST_IDLE;
               end else if (startOfFrame) begin
                  if (frm_inc >= {1'b0, period}) begin
                     state_d = ST_STEP;
                     frm_d   = '0;
                  end else begin
                     frm_d = frm_inc[7:0];
                  end
               end
            end
            ST_STEP: begin
               if (!playGame) begin
                  state_d = ST_IDLE;
               end else if (at_edge) begin
                  state_d = ST_DESCEND;
               end else begin
                  x_d     = nx[10:0];
                  state_d = ST_WAIT;
               end
            end
            ST_DESCEND: begin
               if (!playGame) begin
                  state_d = ST_IDLE;
               end else begin
                  y_d     = y_q + 11'(STEP_Y);
                  dir_d   = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                  state_d = ST_WAIT;
               end
            end
            ST_DEFEATED: begin
`ifdef ALIEN_FORMATION_WAVE_EN
               if (startOfFrame) begin
                  if (frm_inc >= 9'(WAVE_HOLD_FRAMES)) begin
                     alive_d = '1;
                     cnt_d   = 8'(TOTAL);
                     x_d     = 11'(START_X);
                     y_d     = 11'(START_Y + STEP_Y * int'(wave_nxt));
                     wave_d  = wave_nxt;
                     dir_d   = DIR_RIGHT;
                     frm_d   = '0;
                     state_d = ST_IDLE;
                  end else begin
                     frm_d = frm_inc[7:0];
                  end
               end
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_RIGHT;
         x_q     <= 11'(START_X);
         y_q     <= 11'(START_Y);
         frm_q   <= '0;
         alive_q <= '1;
         cnt_q   <= 8'(TOTAL);
         kill_q  <= 1'b0;
         draw_q  <= 1'b0;
         offx_q  <= '0;
         offy_q  <= '0;
         type_q  <= '0;
         hidx_q  <= '0;
`ifdef ALIEN_FORMATION_WAVE_EN
         wave_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         x_q     <= x_d;
         y_q     <= y_d;
         frm_q   <= frm_d;
         alive_q <= alive_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
         draw_q  <= draw_d;
         offx_q  <= offx_d;
         offy_q  <= offy_d;
         type_q  <= type_d;
         hidx_q  <= hidx_d;
`ifdef ALIEN_FORMATION_WAVE_EN
         wave_q  <= wave_d;
`endif
      end
   end

   assign drawingRequest = draw_q;
   assign offsetX        = offx_q;
   assign offsetY        = offy_q;
   assign alienType      = type_q;
   assign topLeftX       = x_q;
   assign topLeftY       = y_q;
   assign aliveCount     = cnt_q;
   assign killPulse      = kill_q;
   assign matrixDefeated = (cnt_q == 8'd0);
   assign bottomY        = span_any ? y_q + ((11'(max_row) + 11'd1) << CH_SH) : y_q;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Bench for alien_formation_ctrl: decode table, march/kill sequences, random hits against a cell-map model.
module tb_alien_formation_ctrl;

   localparam int ROWS = 4;
   localparam int COLS = 8;
   localparam int CW   = 32;
   localparam int CH   = 32;

   logic        clk = 1'b0;
   logic        resetN, startOfFrame, playGame, fireCollision;
   logic [10:0] pixelX, pixelY;
   logic        drawingRequest, killPulse, matrixDefeated;
   logic [10:0] offsetX, offsetY, topLeftX, topLeftY, bottomY;
   logic [1:0]  alienType;
   logic [7:0]  aliveCount;

   always #5 clk = ~clk;

   alien_formation_ctrl dut (
      .clk            (clk),
      .resetN         (resetN),
      .startOfFrame   (startOfFrame),
      .playGame       (playGame),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .fireCollision  (fireCollision),
      .drawingRequest (drawingRequest),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .alienType      (alienType),
      .topLeftX       (topLeftX),
      .topLeftY       (topLeftY),
      .aliveCount     (aliveCount),
      .bottomY        (bottomY),
      .killPulse      (killPulse),
      .matrixDefeated (matrixDefeated)
   );

   int n_tests = 0;
   int n_fail  = 0;

   bit ma[ROWS][COLS];
   int mx, my;
   bit mleft;

   typedef struct {
      int px; int py; int dr; int ox; int oy; int ty;
   } vec_t;
   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
   endtask

   function automatic int m_count();
      int n = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (ma[r][c]) n++;
      return n;
   endfunction

   function automatic int m_mincol();
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (ma[r][c]) return c;
      return 0;
   endfunction

   function automatic int m_maxcol();
      for (int c = COLS - 1; c >= 0; c--)
         for (int r = 0; r < ROWS; r++)
            if (ma[r][c]) return c;
      return 0;
   endfunction

   function automatic int m_bottom();
      for (int r = ROWS - 1; r >= 0; r--)
         for (int c = 0; c < COLS; c++)
            if (ma[r][c]) return my + (r + 1) * CH;
      return my;
   endfunction

   function automatic int m_period();
      int p;
      p = 32 - (ROWS * COLS - m_count());
      return (p < 2) ? 2 : p;
   endfunction

   // One march move: count pulses until the origin changes and compare with the rule-derived target.
   task automatic do_move();
      int exp_p, pulses, ox, oy, nx, ex, ey;
      bit moved;
      exp_p = m_period();
      ox = mx;
      oy = my;
      nx = mleft ? mx - 4 : mx + 4;
      if (nx + m_mincol() * CW < 0 || nx + (m_maxcol() + 1) * CW > 640) begin
         ex = mx;
         ey = my + 16;
         mleft = !mleft;
      end else begin
         ex = nx;
         ey = my;
      end
      pulses = 0;
      moved = 1'b0;
      while (!moved && pulses < 64) begin
         frame();
         pulses++;
         if (int'(topLeftX) != ox || int'(topLeftY) != oy) moved = 1'b1;
      end
      check("move_period", pulses, exp_p);
      check("move_x", int'(topLeftX), ex);
      check("move_y", int'(topLeftY), ey);
      mx = ex;
      my = ey;
   endtask

   task automatic kill_cell(input int r, input int c);
      int exp;
      pixelX = 11'(mx + c * CW + 5);
      pixelY = 11'(my + r * CH + 5);
      tick();
      exp = int'(ma[r][c]);
      check("kill_draw", int'(drawingRequest), exp);
      fireCollision = 1'b1;
      tick();
      fireCollision = 1'b0;
      ma[r][c] = 1'b0;
      check("kill_pulse", int'(killPulse), exp);
      check("kill_count", int'(aliveCount), m_count());
      if (m_count() > 0) check("kill_bottom", int'(bottomY), m_bottom());
      tick();
      check("kill_pulse_drop", int'(killPulse), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int px, py, rx, ry, e, f;
      bit desc;

      vecs[0] = '{64,  32,  1, 0,  0,  0};
      vecs[1] = '{95,  63,  1, 31, 31, 0};
      vecs[2] = '{96,  64,  1, 0,  0,  0};
      vecs[3] = '{319, 159, 1, 31, 31, 1};
      vecs[4] = '{200, 100, 1, 8,  4,  1};
      vecs[5] = '{320, 100, 0, 0,  0,  0};
      vecs[6] = '{63,  40,  0, 0,  0,  0};
      vecs[7] = '{100, 160, 0, 0,  0,  0};
      vecs[8] = '{100, 31,  0, 0,  0,  0};

      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            ma[r][c] = 1'b1;
      mx = 64;
      my = 32;
      mleft = 1'b0;

      resetN = 1'b1;
      startOfFrame = 1'b0;
      playGame = 1'b0;
      fireCollision = 1'b0;
      pixelX = '0;
      pixelY = '0;
      tick();
      tick();
      check("rst_draw", int'(drawingRequest), 0);
      check("rst_kill", int'(killPulse), 0);
      check("rst_offx", int'(offsetX), 0);
      check("rst_offy", int'(offsetY), 0);
      check("rst_x", int'(topLeftX), 64);
      check("rst_y", int'(topLeftY), 32);
      check("rst_count", int'(aliveCount), 32);
      check("rst_bottom", int'(bottomY), 160);
      check("rst_defeated", int'(matrixDefeated), 0);
      resetN = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         pixelX = 11'(vecs[i].px);
         pixelY = 11'(vecs[i].py);
         tick();
         check("vec_draw", int'(drawingRequest), vecs[i].dr);
         if (vecs[i].dr != 0) begin
            check("vec_offx", int'(offsetX), vecs[i].ox);
            check("vec_offy", int'(offsetY), vecs[i].oy);
            check("vec_type", int'(alienType), vecs[i].ty);
         end
      end

      // First move: 32 pulses, origin changes one clk after the 32nd.
      playGame = 1'b1;
      tick();
      for (int i = 0; i < 31; i++) frame();
      check("x_hold_31", int'(topLeftX), 64);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("x_at_pulse32", int'(topLeftX), 64);
      tick();
      check("x_after_step", int'(topLeftX), 68);
      check("count_after_step", int'(aliveCount), 32);
      mx = 68;
      playGame = 1'b0;
      tick();
      tick();
      check("x_hold_idle", int'(topLeftX), 68);

      kill_cell(0, 0);
      kill_cell(0, 0);
      check("period_31_count", int'(aliveCount), 31);

      playGame = 1'b1;
      tick();
      do_move();
      playGame = 1'b0;
      tick();

      for (int r = 0; r < ROWS; r++) kill_cell(r, 7);

      playGame = 1'b1;
      tick();
      desc = 1'b0;
      for (int i = 0; i < 200 && !desc; i++) begin
         int oy;
         oy = my;
         do_move();
         if (my != oy) desc = 1'b1;
      end
      check("descended", int'(desc), 1);
      check("descend_x", mx, 416);
      do_move();
      check("left_move_x", int'(topLeftX), 412);
      playGame = 1'b0;
      tick();

      for (int c = 0; c < COLS; c++) kill_cell(3, c);
      check("row3_bottom", int'(bottomY), my + 96);

      for (int i = 0; i < 300; i++) begin
         px = mx - 16 + int'($urandom_range(0, COLS * CW + 32));
         py = my - 16 + int'($urandom_range(0, ROWS * CH + 32));
         pixelX = 11'(px);
         pixelY = 11'(py);
         tick();
         rx = px - mx;
         ry = py - my;
         e = (rx >= 0 && rx < COLS * CW && ry >= 0 && ry < ROWS * CH) ? int'(ma[ry / CH][rx / CW]) : 0;
         check("rnd_draw", int'(drawingRequest), e);
         if (e != 0) begin
            check("rnd_offx", int'(offsetX), rx % CW);
            check("rnd_offy", int'(offsetY), ry % CH);
            check("rnd_type", int'(alienType), (ry / CH) / 2);
         end
         f = int'($urandom_range(0, 1));
         fireCollision = f[0];
         tick();
         fireCollision = 1'b0;
         check("rnd_kill", int'(killPulse), f & e);
         if ((f & e) != 0) ma[ry / CH][rx / CW] = 1'b0;
         check("rnd_count", int'(aliveCount), m_count());
      end

      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (ma[r][c]) kill_cell(r, c);
      tick();
      check("defeated_now", int'(matrixDefeated), 1);
      check("defeated_count", int'(aliveCount), 0);

`ifdef ALIEN_FORMATION_WAVE_EN
      for (int i = 0; i < 59; i++) frame();
      check("wave_hold", int'(matrixDefeated), 1);
      frame();
      check("wave_cleared", int'(matrixDefeated), 0);
      check("wave_count", int'(aliveCount), 32);
      check("wave_x", int'(topLeftX), 64);
      check("wave_y", int'(topLeftY), 48);
`else
      for (int i = 0; i < 70; i++) frame();
      check("defeat_terminal", int'(matrixDefeated), 1);
      check("defeat_count", int'(aliveCount), 0);
      check("defeat_y_held", int'(topLeftY), my);
`endif

      playGame = 1'b1;
      for (int i = 0; i < 5; i++) frame();
      startOfFrame = 1'b1;
      resetN = 1'b1;
      tick();
      startOfFrame = 1'b0;
      resetN = 1'b0;
      check("midrst_x", int'(topLeftX), 64);
      check("midrst_y", int'(topLeftY), 32);
      check("midrst_count", int'(aliveCount), 32);
      check("midrst_defeated", int'(matrixDefeated), 0);
      check("midrst_bottom", int'(bottomY), 160);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
